// File: rtl/mem_pkg.sv
// Shared defaults, region select codes and region type for the banked memory
// subsystem.
package mem_pkg;
   localparam int DEF_DATA_W = 19;
   localparam int DEF_ADDR_W = 19;
   localparam int DEF_SEL_W  = 3;

   localparam logic [2:0] SEL_FFT    = 3'b111;
   localparam logic [2:0] SEL_CRYPTO = 3'b110;

   typedef enum logic [1:0] {
      REG_DMEM,
      REG_ACC,
      REG_UNMAPPED
   } region_e;
endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: splits a word address into data bank,
// accelerator window (index + offset) or unmapped.
module mem_region_decode
   import mem_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int SEL_W        = DEF_SEL_W,
   parameter int DMEM_DEPTH   = 65536,
   parameter int N_ACC        = 2,
   parameter int ACC_DEPTH    = 1024,
   parameter int ACC_SEL_BASE = 7,
   localparam int ACC_AW      = $clog2(ACC_DEPTH),
   localparam int WIN_W       = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
   input  logic [ADDR_W-1:0] addr_i,
   output region_e           region_o,
   output logic [WIN_W-1:0]  win_o,
   output logic [ACC_AW-1:0] offset_o
);
   localparam int LOW_W = ADDR_W - SEL_W;

   logic [SEL_W-1:0] sel;
   logic [LOW_W-1:0] low;

   assign sel = addr_i[ADDR_W-1 -: SEL_W];
   assign low = addr_i[LOW_W-1:0];

   always_comb begin
      region_o = (addr_i < ADDR_W'(DMEM_DEPTH)) ? REG_DMEM : REG_UNMAPPED;
      win_o    = '0;
      offset_o = addr_i[ACC_AW-1:0];
      // Window codes count down from the base; a window claims its whole
      // select code, so stray bits above the offset make it unmapped.
      for (int k = 0; k < N_ACC; k++) begin
         if (sel == SEL_W'(ACC_SEL_BASE - k)) begin
            win_o    = WIN_W'(k);
            region_o = (((low >> ACC_AW) != '0) || (int'(offset_o) >= ACC_DEPTH))
                       ? REG_UNMAPPED : REG_ACC;
         end
      end
   end
endmodule

// File: rtl/banked_mem_arb.sv
// Single-port banked memory (data bank + accelerator windows) shared by the
// CPU and accelerator ports, with anti-starvation arbitration.
module banked_mem_arb
   import mem_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int SEL_W        = DEF_SEL_W,
   parameter int DMEM_DEPTH   = 65536,
   parameter int N_ACC        = 2,
   parameter int ACC_DEPTH    = 1024,
   parameter int ACC_SEL_BASE = int'(SEL_FFT),
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   input  logic              acc_req,
   input  logic              acc_we,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   output logic              acc_gnt,
   output logic              acc_rvalid,
   output logic [DATA_W-1:0] acc_rdata,
   output logic              acc_err
);
   localparam int ACC_AW  = $clog2(ACC_DEPTH);
   localparam int WIN_W   = (N_ACC > 1) ? $clog2(N_ACC) : 1;
   localparam int DMEM_AW = $clog2(DMEM_DEPTH);
   localparam int CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [CNT_W-1:0] stall_q, stall_d;
   logic             force_acc;

   // Handshake: a port's access happens in the cycle req && gnt are both high;
   // an ungranted requester keeps req and its command stable until granted.
   always_comb begin
      force_acc = (STARVE_LIMIT > 0) && (stall_q == CNT_W'(STARVE_LIMIT));
      acc_gnt   = !rst && acc_req && (!cpu_req || force_acc);
      cpu_gnt   = !rst && cpu_req && !acc_gnt;
      stall_d   = stall_q;
      if (!acc_req || acc_gnt) begin
         stall_d = '0;
      end else if (stall_q != CNT_W'(STARVE_LIMIT)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   logic              gnt_any, m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, rd_word;
   region_e           m_region;
   logic [WIN_W-1:0]  m_win;
   logic [ACC_AW-1:0] m_off;
   logic              m_unmapped;

   assign gnt_any    = cpu_gnt || acc_gnt;
   assign m_we       = acc_gnt ? acc_we    : cpu_we;
   assign m_addr     = acc_gnt ? acc_addr  : cpu_addr;
   assign m_wdata    = acc_gnt ? acc_wdata : cpu_wdata;
   assign m_unmapped = (m_region == REG_UNMAPPED);

   mem_region_decode #(
      .ADDR_W       (ADDR_W),
      .SEL_W        (SEL_W),
      .DMEM_DEPTH   (DMEM_DEPTH),
      .N_ACC        (N_ACC),
      .ACC_DEPTH    (ACC_DEPTH),
      .ACC_SEL_BASE (ACC_SEL_BASE)
   ) u_decode (
      .addr_i   (m_addr),
      .region_o (m_region),
      .win_o    (m_win),
      .offset_o (m_off)
   );

   logic [DATA_W-1:0] dmem [DMEM_DEPTH];
   logic [DATA_W-1:0] amem [N_ACC][ACC_DEPTH];

   always_ff @(posedge clk) begin
      if (gnt_any && m_we) begin
         case (m_region)
            REG_DMEM: dmem[m_addr[DMEM_AW-1:0]] <= m_wdata;
            REG_ACC:  amem[m_win][m_off]        <= m_wdata;
            default:  ;
         endcase
      end
   end

   always_comb begin
      case (m_region)
         REG_DMEM: rd_word = dmem[m_addr[DMEM_AW-1:0]];
         REG_ACC:  rd_word = amem[m_win][m_off];
         default:  rd_word = '0;
      endcase
   end

   logic              cpu_rvalid_q, cpu_err_q, acc_rvalid_q, acc_err_q;
   logic [DATA_W-1:0] cpu_rdata_q, acc_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q      <= '0;
         cpu_rvalid_q <= 1'b0;
         cpu_err_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         acc_rvalid_q <= 1'b0;
         acc_err_q    <= 1'b0;
         acc_rdata_q  <= '0;
      end else begin
         stall_q      <= stall_d;
         cpu_rvalid_q <= cpu_gnt && !cpu_we;
         cpu_err_q    <= cpu_gnt && m_unmapped;
         acc_rvalid_q <= acc_gnt && !acc_we;
         acc_err_q    <= acc_gnt && m_unmapped;
         if (cpu_gnt && !cpu_we) cpu_rdata_q <= rd_word;
         if (acc_gnt && !acc_we) acc_rdata_q <= rd_word;
      end
   end

   // Masking with rst hides a response registered just before reset rose.
   assign cpu_rvalid = cpu_rvalid_q && !rst;
   assign cpu_err    = cpu_err_q && !rst;
   assign cpu_rdata  = rst ? '0 : cpu_rdata_q;
   assign acc_rvalid = acc_rvalid_q && !rst;
   assign acc_err    = acc_err_q && !rst;
   assign acc_rdata  = rst ? '0 : acc_rdata_q;
endmodule

// File: tb/tb_banked_mem_arb.sv
// Randomized and directed bench for banked_mem_arb against an address-keyed
// reference memory and a starvation-count arbitration model.
module tb_banked_mem_arb;
   localparam int DW  = 19;
   localparam int AW  = 19;
   localparam int LIM = 4;
   localparam int RW  = 2 * (DW + 2);

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          cpu_req, cpu_we, acc_req, acc_we;
   logic [AW-1:0] cpu_addr, acc_addr;
   logic [DW-1:0] cpu_wdata, acc_wdata;
   logic          cpu_gnt, cpu_rvalid, cpu_err, acc_gnt, acc_rvalid, acc_err;
   logic [DW-1:0] cpu_rdata, acc_rdata;
   logic          c0_gnt, c0_rvalid, c0_err, a0_gnt, a0_rvalid, a0_err;
   logic [DW-1:0] c0_rdata, a0_rdata;

   banked_mem_arb #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
      .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata), .acc_err(acc_err)
   );

   banked_mem_arb #(.STARVE_LIMIT(0)) dut0 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(c0_gnt), .cpu_rvalid(c0_rvalid), .cpu_rdata(c0_rdata), .cpu_err(c0_err),
      .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
      .acc_gnt(a0_gnt), .acc_rvalid(a0_rvalid), .acc_rdata(a0_rdata), .acc_err(a0_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model
   logic [DW-1:0] mem_m [int];
   int            run_m;
   logic [DW-1:0] last_cpu, last_acc;
   logic [RW-1:0] exp_q[$];
   logic          g_cpu_m, g_acc_m;
   int            acc_gnt_seen, acc0_gnt_seen;

   function automatic int key_of(input logic [AW-1:0] a);
      int sel, low;
      sel = int'(a) >> 16;
      low = int'(a) & 'hFFFF;
      if (sel == 7 || sel == 6) begin
         if (low >= 1024) return -1;
         return 'h100000 + (7 - sel) * 1024 + low;
      end
      if (int'(a) >= 65536) return -1;
      return int'(a);
   endfunction

   // driver + scoreboard for one clock cycle, entered and left at a negedge
   task automatic step(input logic r,
                       input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
      logic [RW-1:0] e;
      logic          c_rv, c_er, a_rv, a_er;
      logic [DW-1:0] c_rd, a_rd;
      int            k;
      rst = r;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      acc_req = ar; acc_we = aw; acc_addr = aa; acc_wdata = ad;
      #1;
      if (acc_gnt) acc_gnt_seen++;
      if (a0_gnt) acc0_gnt_seen++;
      if (r) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         check("rst_cpu_gnt", cpu_gnt, 0);
         check("rst_acc_gnt", acc_gnt, 0);
         check("rst_cpu_rvalid", cpu_rvalid, 0);
         check("rst_cpu_err", cpu_err, 0);
         check("rst_cpu_rdata", cpu_rdata, 0);
         check("rst_acc_rvalid", acc_rvalid, 0);
         check("rst_acc_err", acc_err, 0);
         check("rst_acc_rdata", acc_rdata, 0);
         g_cpu_m = 1'b0;
         g_acc_m = 1'b0;
         run_m = 0;
         last_cpu = '0;
         last_acc = '0;
         exp_q.push_back('0);
      end else begin
         if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            e = '0;
         end else begin
            e = exp_q.pop_front();
         end
         {c_rv, c_er, c_rd, a_rv, a_er, a_rd} = e;
         check("cpu_rvalid", cpu_rvalid, c_rv);
         check("cpu_err", cpu_err, c_er);
         check("cpu_rdata", cpu_rdata, c_rd);
         check("acc_rvalid", acc_rvalid, a_rv);
         check("acc_err", acc_err, a_er);
         check("acc_rdata", acc_rdata, a_rd);

         g_acc_m = ar && (!cr || run_m == LIM);
         g_cpu_m = cr && !g_acc_m;
         check("cpu_gnt", cpu_gnt, g_cpu_m);
         check("acc_gnt", acc_gnt, g_acc_m);
         check("nolim_cpu_gnt", c0_gnt, cr);
         check("nolim_acc_gnt", a0_gnt, ar && !cr);

         c_rv = 1'b0; c_er = 1'b0; c_rd = last_cpu;
         a_rv = 1'b0; a_er = 1'b0; a_rd = last_acc;
         if (g_cpu_m) begin
            k = key_of(ca);
            c_er = (k < 0);
            if (!cw) begin
               c_rv = 1'b1;
               c_rd = (k < 0) ? '0 : mem_m[k];
            end else if (k >= 0) begin
               mem_m[k] = cd;
            end
         end
         if (g_acc_m) begin
            k = key_of(aa);
            a_er = (k < 0);
            if (!aw) begin
               a_rv = 1'b1;
               a_rd = (k < 0) ? '0 : mem_m[k];
            end else if (k >= 0) begin
               mem_m[k] = ad;
            end
         end
         last_cpu = c_rd;
         last_acc = a_rd;
         exp_q.push_back({c_rv, c_er, c_rd, a_rv, a_er, a_rd});
         if (!ar || g_acc_m) run_m = 0;
         else if (run_m < LIM) run_m++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic cpu_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      step(0, 1, w, a, d, 0, 0, '0, '0);
   endtask

   task automatic acc_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      step(0, 0, 0, '0, '0, 1, w, a, d);
   endtask

   logic [AW-1:0] pool [12];
   logic          cr, cw, ar, aw;
   logic [AW-1:0] ca, aa;
   logic [DW-1:0] cd, ad;

   initial begin
      pool = '{19'h00010, 19'h00020, 19'h00005, 19'h0FFFF, 19'h70005, 19'h703FF,
               19'h70000, 19'h60005, 19'h70400, 19'h10000, 19'h5FFFF, 19'h6A000};
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      acc_req = 0; acc_we = 0; acc_addr = '0; acc_wdata = '0;
      acc_gnt_seen = 0; acc0_gnt_seen = 0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, 0, 0, '0, '0);

      // basic CPU write/read
      cpu_op(1, 19'h00010, 19'h1ABCD);
      cpu_op(0, 19'h00010, '0);
      idle(1);

      // FFT window vs crypto window vs data bank, no aliasing
      acc_op(1, 19'h70005, 19'h00042);
      cpu_op(1, 19'h60005, 19'h00003);
      cpu_op(1, 19'h00005, 19'h00777);
      cpu_op(0, 19'h70005, '0);
      cpu_op(0, 19'h60005, '0);
      cpu_op(0, 19'h00005, '0);
      idle(1);

      // contention: 20 cycles, acc wins every 5th with limit 4, never with 0
      acc_gnt_seen = 0; acc0_gnt_seen = 0;
      for (int i = 0; i < 20; i++) step(0, 1, 0, 19'h00010, '0, 1, 0, 19'h70005, '0);
      check("starve_acc_grants", acc_gnt_seen, 4);
      check("strict_acc_grants", acc0_gnt_seen, 0);
      idle(2);

      // unmapped window offset: err + zero data, write dropped
      acc_op(1, 19'h70000, 19'h12345);
      cpu_op(0, 19'h70400, '0);
      cpu_op(1, 19'h70400, 19'h7FFFF);
      cpu_op(0, 19'h70000, '0);
      cpu_op(0, 19'h10000, '0);
      idle(1);

      // reset right after a read grant suppresses the response; memory survives
      cpu_op(0, 19'h00010, '0);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0);
      step(1, 0, 0, '0, '0, 0, 0, '0, '0);
      idle(1);
      cpu_op(0, 19'h00010, '0);
      idle(1);

      // read-after-write on consecutive cycles
      cpu_op(1, 19'h00020, 19'h0BEEF);
      cpu_op(0, 19'h00020, '0);
      idle(1);

      // prefill every pool address so random reads have known contents
      for (int i = 0; i < 12; i++) cpu_op(1, pool[i], DW'($urandom_range(0, (1 << DW) - 1)));

      // random traffic; an ungranted requester holds its command
      cr = 0; cw = 0; ca = '0; cd = '0; ar = 0; aw = 0; aa = '0; ad = '0;
      g_cpu_m = 0; g_acc_m = 0;
      for (int i = 0; i < 400; i++) begin
         if (!(cr && !g_cpu_m)) begin
            cr = ($urandom_range(0, 3) != 0);
            cw = ($urandom_range(0, 2) == 0);
            ca = pool[$urandom_range(0, 11)];
            cd = DW'($urandom_range(0, (1 << DW) - 1));
         end
         if (!(ar && !g_acc_m)) begin
            ar = ($urandom_range(0, 2) != 0);
            aw = ($urandom_range(0, 2) == 0);
            aa = pool[$urandom_range(0, 11)];
            ad = DW'($urandom_range(0, (1 << DW) - 1));
         end
         step(($urandom_range(0, 99) == 0), cr, cw, ca, cd, ar, aw, aa, ad);
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/banked_mem_arb.md
Name: banked_mem_arb

Overview:
Parametrised successor of the unified data memory. Single-port memory subsystem that address-decodes into a data bank and N_ACC accelerator windows (FFT, crypto, ...). It arbitrates between the CPU data port and an accelerator/DMA port, with registered reads, a response-valid handshake and unmapped-access error reporting. Sits between the pipeline MEM stage, the accelerator engines and the on-chip SRAM banks.

Parameters:
DATA_W, 19, word width
ADDR_W, 19, byte-free word address width
SEL_W, 3, number of top address bits used as region select
DMEM_DEPTH, 65536, data bank words (must be <= 2^(ADDR_W-SEL_W))
N_ACC, 2, number of accelerator windows
ACC_DEPTH, 1024, words per accelerator window
ACC_SEL_BASE, 7, select code of window 0; window k uses code ACC_SEL_BASE-k (default: FFT=3'b111, crypto=3'b110)
STARVE_LIMIT, 4, consecutive acc denials before acc is forced to win; 0 = strict CPU priority

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_gnt  out  1  request accepted this cycle (combinational)
cpu_rvalid  out  1  read data valid (one cycle after read grant)
cpu_rdata  out  DATA_W  read data
cpu_err  out  1  unmapped access (one cycle after grant, reads and writes)
acc_req, acc_we, acc_addr, acc_wdata, acc_gnt, acc_rvalid, acc_rdata, acc_err  same directions/widths/meaning for accelerator port

Behaviour:
- Decode on addr[ADDR_W-1 -: SEL_W]: code ACC_SEL_BASE-k (k<N_ACC) -> window k, offset addr[clog2(ACC_DEPTH)-1:0]; all other codes -> data bank, index = full addr.
- Unmapped: window offset bits between clog2(ACC_DEPTH) and the select field nonzero, or data index >= DMEM_DEPTH. Write dropped; read returns rdata=0; err=1 with rvalid timing.
- Exactly one port granted per cycle; no grants while rst=1.
- Arbitration: CPU wins when both request, unless stall_cnt == STARVE_LIMIT (STARVE_LIMIT>0), then acc wins and stall_cnt clears.
- stall_cnt: +1 each cycle acc_req && !acc_gnt (saturates at STARVE_LIMIT); cleared on acc grant or when acc_req=0.
- Single requester -> granted immediately.
- Write: array updated at the clock edge of the grant cycle.
- Read: granted read -> rdata/rvalid registered at the next edge; latency 1. Read granted the cycle after a write to the same address returns the new data.
- Response goes only to the granted port; other port's rvalid/err stay 0. rvalid/err are single-cycle pulses; rdata holds its last value when rvalid=0.
- Reset: all rvalid, err, rdata = 0; stall_cnt = 0; in-flight read response suppressed. Array contents not reset.
- Ungranted requester must hold its request; no queuing inside the block.

Decomposition:
- Package mem_pkg: DATA_W/ADDR_W/SEL_W defaults, region select constants (SEL_FFT=3'b111, SEL_CRYPTO=3'b110), region enum {REG_DMEM, REG_ACC, REG_UNMAPPED}.
- One sub-module: mem_region_decode (combinational addr -> region, window index, offset, unmapped flag). Arbiter and banks inline.

Test Plan:
- CPU write 0x00010 <- 0x1ABCD, then read 0x00010 -> gnt same cycle; rvalid next cycle with rdata=0x1ABCD, err=0.
- Acc write 0x70005 <- 0x00042 (FFT window), CPU read 0x70005 -> 0x00042; CPU read 0x60005 (crypto) -> independent contents, no aliasing.
- Both ports request reads continuously, STARVE_LIMIT=4 -> CPU granted 4 cycles, acc on the 5th; pattern repeats. With STARVE_LIMIT=0 acc is never granted.
- CPU read 0x70400 (offset >= 1024 in FFT window) -> err=1, rvalid=1, rdata=0; write to same address leaves window contents unchanged.
- Read granted, rst asserted next cycle -> no rvalid pulse; outputs 0, stall_cnt 0; memory data written before reset still readable afterwards.
- Write 0x00020 in cycle n, read 0x00020 in cycle n+1 -> new value returned at n+2.
